// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: valid/ready request in, fixed wait states,
// word read from a local array, valid/ready response out, plus a program-load port.
module imem_fetch_responder #(
    parameter int n_bit       = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [n_bit-1:0]      req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [n_bit-1:0]      rsp_instr,
    output logic                  rsp_err,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [n_bit-1:0]      prog_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [n_bit-1:0]        mem [DEPTH];

    logic                    req_err;
    logic [DEPTH_LOG2-1:0]   req_idx;

    // Any address bit above the array's word range set means out of range; no aliasing.
    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);
    assign req_idx = req_addr[DEPTH_LOG2+1:2];

    // Unreset so boot logic can load the array while the FSM is held in reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        idx       <= req_idx;
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_instr <= '0;
                            state     <= RESP;
                        end else if (WAIT_CYCLES == 0) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_instr <= mem[req_idx];
                            state     <= RESP;
                        end else begin
                            cnt   <= 4'(WAIT_CYCLES);
                            state <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Read sees the pre-edge array contents, so a same-edge write returns old data.
                    if (cnt == 4'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_instr <= mem[idx];
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_instr <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a WAIT_CYCLES=2 instance driven with directed and
// random fetches against a shadow-array model, plus a zero-wait instance.
module tb_imem_fetch_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, rsp_instr;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;

    logic        r0_valid, r0_ready, p0_valid, p0_ready, p0_err;
    logic [31:0] r0_addr, p0_instr;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_mem [256];

    always #5 clk = ~clk;

    imem_fetch_responder #(.n_bit(32), .DEPTH_LOG2(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_fetch_responder #(.n_bit(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_addr(r0_addr),
        .rsp_valid(p0_valid), .rsp_ready(p0_ready), .rsp_instr(p0_instr), .rsp_err(p0_err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return model_err(a) ? 32'h0 : model_mem[a / 4];
    endfunction

    function automatic int model_lat(input logic [31:0] a);
        return model_err(a) ? 1 : W + 1;
    endfunction

    // Issues one fetch, holds rsp_ready low for 'hold' cycles after rsp_valid, then handshakes.
    // lat = edges from acceptance until rsp_valid is sampled high (-1 on timeout).
    task automatic fetch(input logic [31:0] a, input int hold, output int lat,
                         output logic [31:0] instr, output logic err,
                         output logic held_ok, output logic idle_ok);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0; req_addr = $urandom;
        n = 1;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        lat = rsp_valid ? n : -1;
        instr = rsp_instr; err = rsp_err; held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom % 2); req_addr = {$urandom % 256, 2'b00};
            tick();
            if (!rsp_valid || rsp_instr !== instr || rsp_err !== err || req_ready) held_ok = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        idle_ok = req_ready && !rsp_valid && rsp_instr === 32'h0 && rsp_err === 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 0; req_addr = 0; rsp_ready = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        r0_valid = 0; r0_addr = 0; p0_ready = 0;
        tick(); tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: ready/valid/err=%b%b%b instr=%h, want 000 / 0",
                     req_ready, rsp_valid, rsp_err, rsp_instr);
        end
        checks++;
        if (r0_ready !== 1'b0 || p0_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs_w0: ready=%b valid=%b, want 0 0", r0_ready, p0_valid);
        end
        for (int i = 0; i < 256; i++) prog(8'(i), $urandom);
        prog(8'd0, 32'h20080005);
        prog(8'd1, 32'h20090007);
        prog(8'd2, 32'h01095020);
        prog(8'd3, 32'hAC0A0000);
        reset_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] instr; logic err, hok, iok;
        fetch(32'h8, 0, lat, instr, err, hok, iok);
        checks++;
        if (lat !== 3 || instr !== 32'h01095020 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_fetch: lat=%0d instr=%h err=%b, want 3 01095020 0", lat, instr, err);
        end
        checks++;
        if (!iok) begin
            failures++;
            $display("FAIL basic_idle: ready=%b valid=%b instr=%h, want 1 0 0", req_ready, rsp_valid, rsp_instr);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] instr; logic err, hok, iok;
        logic [31:0] addrs [3] = '{32'h6, 32'h400, 32'hFFFF_FFFC};
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], 0, lat, instr, err, hok, iok);
            checks++;
            if (lat !== 1 || instr !== 32'h0 || err !== 1'b1 || !iok) begin
                failures++;
                $display("FAIL err_fetch_%h: lat=%0d instr=%h err=%b idle=%b, want 1 0 1 1",
                         addrs[i], lat, instr, err, iok);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] instr; logic err, hok, iok;
        fetch(32'h4, 5, lat, instr, err, hok, iok);
        checks++;
        if (lat !== 3 || instr !== 32'h20090007 || err !== 1'b0) begin
            failures++;
            $display("FAIL bp_fetch: lat=%0d instr=%h err=%b, want 3 20090007 0", lat, instr, err);
        end
        checks++;
        if (!hok || !iok) begin
            failures++;
            $display("FAIL bp_hold: held=%b idle=%b, want 1 1", hok, iok);
        end
    endtask

    task automatic test_collision();
        int lat; logic [31:0] instr, old; logic err, hok, iok;
        old = model_mem[0];
        req_valid = 1'b1; req_addr = 32'h0;
        tick();                                 // acceptance edge
        req_valid = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'hFFFF_FFFF;
        tick();                                 // read edge coincides with the write
        prog_we = 1'b0;
        model_mem[0] = 32'hFFFF_FFFF;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== old || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL collision_old: valid=%b instr=%h err=%b, want 1 %h 0",
                     rsp_valid, rsp_instr, rsp_err, old);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch(32'h0, 0, lat, instr, err, hok, iok);
        checks++;
        if (instr !== 32'hFFFF_FFFF || err !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL collision_new: lat=%0d instr=%h err=%b, want 3 ffffffff 0", lat, instr, err);
        end
    endtask

    task automatic test_reset_midflight();
        int lat; logic [31:0] instr; logic err, hok, iok; logic seen;
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: ready=%b valid=%b, want 0 0", req_ready, rsp_valid);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release_ready: got %b want 1", req_ready);
        end
        seen = rsp_valid;
        for (int i = 0; i < 8; i++) begin tick(); seen |= rsp_valid; end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_rsp: rsp_valid seen=%b want 0", seen);
        end
        fetch(32'hC, 0, lat, instr, err, hok, iok);
        checks++;
        if (lat !== 3 || instr !== 32'hAC0A0000 || err !== 1'b0 || !iok) begin
            failures++;
            $display("FAIL midreset_refetch: lat=%0d instr=%h err=%b idle=%b, want 3 ac0a0000 0 1",
                     lat, instr, err, iok);
        end
    endtask

    task automatic test_random();
        int lat, hold; logic [31:0] a, instr; logic err, hok, iok;
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 5)
                0, 1:    a = {22'h0, 8'($urandom), 2'b00};
                2:       a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
                3:       a = {$urandom | 32'h400} & ~32'h3;
                default: a = $urandom;
            endcase
            if ($urandom % 3 == 0) prog(8'($urandom), $urandom);
            hold = $urandom_range(0, 3);
            fetch(a, hold, lat, instr, err, hok, iok);
            checks++;
            if (lat !== model_lat(a) || instr !== model_data(a) || err !== model_err(a) || !hok || !iok) begin
                failures++;
                $display("FAIL rand_fetch_%h: lat=%0d instr=%h err=%b held=%b idle=%b, want %0d %h %b 1 1",
                         a, lat, instr, err, hok, iok, model_lat(a), model_data(a), model_err(a));
            end
        end
    endtask

    task automatic test_zero_wait();
        int n;
        p0_ready = 1'b1;
        n = 0;
        while (!r0_ready && n < 20) begin tick(); n++; end
        r0_valid = 1'b1; r0_addr = 32'h0;
        tick();                                 // T: accept 0x0
        checks++;
        if (p0_valid !== 1'b1 || p0_instr !== model_mem[0] || p0_err !== 1'b0) begin
            failures++;
            $display("FAIL w0_first: valid=%b instr=%h err=%b, want 1 %h 0", p0_valid, p0_instr, p0_err, model_mem[0]);
        end
        r0_addr = 32'h4;
        tick();                                 // T+1: handshake
        checks++;
        if (r0_ready !== 1'b1 || p0_valid !== 1'b0) begin
            failures++;
            $display("FAIL w0_gap: ready=%b valid=%b, want 1 0", r0_ready, p0_valid);
        end
        tick();                                 // T+2: accept 0x4
        r0_valid = 1'b0;
        checks++;
        if (p0_valid !== 1'b1 || p0_instr !== 32'h20090007 || p0_err !== 1'b0) begin
            failures++;
            $display("FAIL w0_second: valid=%b instr=%h err=%b, want 1 20090007 0", p0_valid, p0_instr, p0_err);
        end
        tick();
        checks++;
        if (p0_valid !== 1'b0 || p0_instr !== 32'h0 || r0_ready !== 1'b1) begin
            failures++;
            $display("FAIL w0_idle: valid=%b instr=%h ready=%b, want 0 0 1", p0_valid, p0_instr, r0_ready);
        end
        p0_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_collision();
        test_reset_midflight();
        test_zero_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder that services fetch requests issued by the program counter.
- Accepts a byte address over a valid/ready request channel and performs a word read from an internal array after a fixed, parameterised wait-state count.
- Returns the instruction, or an error flag, over a valid/ready response channel.
- Includes a program-load write port so the bench or boot logic can fill the array.

Parameters:
- n_bit, 32, data/address width in bits.
- DEPTH_LOG2, 8, log2 of array depth in words (default 256 words = 1 KiB).
- WAIT_CYCLES, 2, wait states between request acceptance and array read (legal 0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  n_bit  fetch byte address.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_instr  output  n_bit  fetched instruction word (0 on error).
- rsp_err  output  1  request was misaligned or out of range.
- prog_we  input  1  program-load write enable.
- prog_addr  input  DEPTH_LOG2  program-load word index.
- prog_data  input  n_bit  program-load data.

Behaviour:
- Interface: one clock, clk. Reset is reset_n, synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: state=IDLE, req_ready=0 while reset_n=0, rsp_valid=0, rsp_instr=0, rsp_err=0, wait counter=0. Array contents are not reset.
- Reset asserted mid-operation: any in-flight fetch is discarded and no response is produced. On the first edge after release, req_ready=1.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid at an edge, latch req_addr.
  - Error check: err = (req_addr[1:0]!=0) or (req_addr[n_bit-1:2] >= 2**DEPTH_LOG2).
  - If err: go to RESP with rsp_instr=0, rsp_err=1 (response 1 cycle after acceptance).
  - Else if WAIT_CYCLES=0: read the array at req_addr[DEPTH_LOG2+1:2] and go to RESP (latency 1).
  - Else: load counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each edge.
  - On the edge where the counter equals 1: read the array word, register it into rsp_instr with rsp_err=0, and go to RESP.
  - Latency for valid requests: acceptance edge T, rsp_valid high from edge T+1+WAIT_CYCLES.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_instr and rsp_err are held stable until the handshake completes.
  - On rsp_ready at an edge: go to IDLE, rsp_valid drops, rsp_instr and rsp_err are cleared to 0.
  - A new request is never accepted in the same cycle as the response handshake. Peak throughput is one fetch per WAIT_CYCLES+2 cycles.
- Program-load port:
  - prog_we writes prog_data to array[prog_addr] on the edge, in any state, including during reset.
  - A write to the word being read on the same edge returns the old data (read-before-write).
  - Writes to other words during WAIT do not disturb the fetch.
- Stability rules:
  - req_addr is sampled only at acceptance; later changes have no effect.
  - req_valid may drop without acceptance (no obligation on the requester).
- All address arithmetic is unsigned; there is no wrap-around. Out-of-range addresses always report an error and never alias.

Test Plan:
- Load array[0..3]=0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 via prog port; request 0x00000008 at edge T with rsp_ready=1 -> rsp_valid at T+3, rsp_instr=0x01095020, rsp_err=0, req_ready back to 1 at T+4.
- Request 0x00000006 (misaligned) -> rsp_valid at T+1, rsp_err=1, rsp_instr=0. Request 0x00000400 (word 256, DEPTH_LOG2=8) -> same error response.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid on a fetch of 0x00000004 -> rsp_instr stays 0x20090007 and rsp_valid stays 1; req_valid pulses during this period are ignored; handshake then returns to IDLE.
- Same-edge collision: request 0x0 with prog_we=1, prog_addr=0, prog_data=0xFFFFFFFF landing on the read edge -> rsp_instr=0x20080005; a following fetch of 0x0 returns 0xFFFFFFFF.
- Assert reset_n=0 for 1 cycle while in WAIT -> no rsp_valid ever appears for that fetch; req_ready=1 on the first edge after release; a subsequent fetch of 0x0000000C returns 0xAC0A0000.
- WAIT_CYCLES=0 build: back-to-back fetches of 0x0 and 0x4 with rsp_ready=1 -> responses at T+1 and T+3, data 0x20080005 and 0x20090007.
